pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with ripple-free group carries inside each stage. The word is split into pipeline stages of `GROUPS_PER_STAGE` groups, with a registered carry between stages and valid/ready flow control on both sides. It is the datapath adder for wide accumulators and ALUs, and replaces hand-instantiated fixed-width lookahead adders.

## Interface
- `WIDTH`, 16: operand/sum width in bits. Must be a multiple of `4*GROUPS_PER_STAGE`; any other value is an elaboration error.
- `GROUPS_PER_STAGE`, 2: 4-bit lookahead groups evaluated per pipeline stage.
- Derived: `STAGES = WIDTH/(4*GROUPS_PER_STAGE)`, which is also the latency in cycles.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  block accepts a beat this cycle
- `a`, `b`  in  WIDTH  operands
- `cin`  in  1  carry-in; ignored when `sub`=1
- `sub`  in  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  downstream accepts result
- `sum`  out  WIDTH  result
- `cout`  out  1  carry out of MSB; for subtract, 1 = no borrow
- `ovf`  out  1  two's-complement signed overflow
- `P`  out  1  word propagate: AND of all bit propagates (a^b')
- `G`  out  1  word generate, independent of carry-in

## Operation
- Effective operand: `b' = sub ? ~b : b`. Effective carry-in: `c0 = sub ? 1 : cin`.
- Stage k (0..STAGES-1) handles bits `[4*GPS*(k+1)-1 : 4*GPS*k]`:
  - per-group p/g and group P/G;
  - in-stage group carries by lookahead from the registered carry-in;
  - registers its sum slice and carry-out.
- Unconsumed high operand bits and completed low sum bits travel with the beat (skew/deskew registers), so all `sum` bits leave together.
- Word `P`/`G` are accumulated across stages: `P = P_hi & P_lo`, `G = G_hi | (P_hi & G_lo)`.
- `ovf = (a[MSB] == b'[MSB]) && (sum_raw[MSB] != a[MSB])`, computed from the pre-saturation sum.
- Flow control:
  - one shared `adv = !out_valid || out_ready`; all pipeline registers, including valid bits, load only when `adv`=1;
  - `in_ready = adv`;
  - a beat is accepted on `in_valid && in_ready`;
  - bubbles are not compressed during a stall;
  - result order always equals accept order.

## Timing
- Latency: a beat accepted at edge n appears with `out_valid`=1 after edge n+STAGES. With out_ready held at 1, throughput is 1 beat/cycle.
- Stall: while `out_valid && !out_ready`, `sum`, `cout`, `ovf`, `P`, `G` and `out_valid` hold stable. `in_ready`=0 in that state.
- `in_ready` is combinational from `out_ready` and registered `out_valid`. There is no combinational path from `a`/`b` to any output.
- Reset values: all stage valid bits 0, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `P`=0, `G`=0. `in_ready`=1 in the first cycle after reset.
- Reset mid-operation: in-flight beats are discarded. No partial result is ever presented.
- Simultaneous accept and output handshake in the same cycle is legal and loses no beat.
- `cin`/`sub` are sampled only on accept. Their values on non-accepted cycles have no effect.
- STAGES=1: a single register stage, latency 1.

## Configuration
- `CLA_SAT_EN` defined: when signed overflow occurs, `sum` clamps to `0111…1` (positive overflow, `a[MSB]`=0) or `1000…0` (negative overflow). `ovf` is still 1. `cout`, `P` and `G` are unchanged.
- Not defined: `sum` wraps modulo 2^WIDTH. No saturation logic is synthesised.

## Test plan
All scenarios use WIDTH=16, GPS=2, out_ready=1 unless stated.
- Carry ripple across stages: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. `out_valid` rises exactly 2 cycles after accept.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Overflow: a=0x7FFF, b=0x0001 -> ovf=1. Without `CLA_SAT_EN`, sum=0x8000; with it, sum=0x7FFF. a=0x8000, b=0xFFFF -> ovf=1; sum=0x7FFF (wrap) or 0x8000 (sat).
- P/G: a=0x00FF, b=0xFF00, cin=1 -> P=1, G=0, sum=0x0000, cout=1.
- Backpressure: stream 4 beats, drop out_ready for 5 cycles mid-stream -> `in_ready`=0 during the stall, outputs stable, all 4 results delivered in order with no duplicates.
- Reset mid-stream, then random soak:
  - assert rst with 2 beats in flight -> `out_valid`=0 next cycle, and neither beat ever appears;
  - then 1000 random beats with random out_ready -> every result matches the reference model.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-lookahead adder/subtractor.
// The word is cut into STAGES = WIDTH/(4*GROUPS_PER_STAGE) register stages.
// Each stage resolves its slice with 4-bit lookahead groups and a group-level
// lookahead carry from the carry registered by the previous stage. Operand
// bits not yet consumed and sum bits already produced travel with the beat,
// so every sum bit leaves together. One shared advance enable moves the pipe.
// Optional build macro: CLA_SAT_EN (saturate sum on signed overflow).
module pipelined_cla_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             P,
    output logic             G
);
    localparam int GPS    = GROUPS_PER_STAGE;
    localparam int SW     = 4 * GPS;
    localparam int STAGES = WIDTH / SW;

    if ((GPS < 1) || (WIDTH < SW) || ((WIDTH % SW) != 0)) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a positive multiple of 4*GROUPS_PER_STAGE");
    end

    // Group propagate/generate of one 4-bit group: {P, G}.
    function automatic logic [1:0] grp_pg(input logic [3:0] p, input logic [3:0] g);
        logic gp;
        logic gg;
        gp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gp, gg};
    endfunction

    // Sum bits of one 4-bit group with fully expanded internal carries.
    function automatic logic [3:0] sum4(input logic [3:0] p, input logic [3:0] g, input logic c);
        logic [3:0] c_v;
        c_v[0] = c;
        c_v[1] = g[0] | (p[0] & c);
        c_v[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        c_v[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return p ^ c_v;
    endfunction

    // Group carries of a stage, each a flat sum-of-products of group G/P and the stage carry-in.
    function automatic logic [GPS:0] grp_carries(input logic [GPS-1:0] gp, input logic [GPS-1:0] gg,
                                                 input logic c);
        logic [GPS:0] c_v;
        logic         term;
        logic         prop;
        c_v = '0;
        for (int j = 0; j <= GPS; j++) begin
            prop = 1'b1;
            for (int m = 0; m < j; m++) prop = prop & gp[m];
            term = prop & c;
            for (int i = 0; i < j; i++) begin
                prop = 1'b1;
                for (int m = i + 1; m < j; m++) prop = prop & gp[m];
                term = term | (gg[i] & prop);
            end
            c_v[j] = term;
        end
        return c_v;
    endfunction

    logic adv_s;
    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO      = k * SW;
        localparam int REM_IN  = WIDTH - LO;
        localparam int REM_OUT = REM_IN - SW;

        logic [REM_IN-1:0] a_in_s;
        logic [REM_IN-1:0] b_in_s;
        logic              c_in_s;
        logic              p_in_s;
        logic              g_in_s;
        logic              v_in_s;
        logic [SW-1:0]     bp_s;
        logic [SW-1:0]     bg_s;
        logic [GPS-1:0]    gp_s;
        logic [GPS-1:0]    gg_s;
        logic [GPS:0]      gc_s;
        logic [SW-1:0]     slice_sum_s;
        logic              slice_p_s;
        logic              slice_g_s;
        logic [LO+SW-1:0]  s_raw_s;
        logic [LO+SW-1:0]  s_d;
        logic [LO+SW-1:0]  s_q;
        logic              v_q;
        logic              c_q;
        logic              p_q;
        logic              g_q;

        if (k == 0) begin : g_first
            assign a_in_s  = a;
            assign b_in_s  = sub ? ~b : b;
            assign c_in_s  = sub ? 1'b1 : cin;
            assign p_in_s  = 1'b1;
            assign g_in_s  = 1'b0;
            assign v_in_s  = in_valid;
            assign s_raw_s = slice_sum_s;
        end else begin : g_next
            assign a_in_s  = g_stage[k-1].g_fwd.a_q;
            assign b_in_s  = g_stage[k-1].g_fwd.b_q;
            assign c_in_s  = g_stage[k-1].c_q;
            assign p_in_s  = g_stage[k-1].p_q;
            assign g_in_s  = g_stage[k-1].g_q;
            assign v_in_s  = g_stage[k-1].v_q;
            assign s_raw_s = {slice_sum_s, g_stage[k-1].s_q};
        end

        // Lookahead evaluation of this stage's slice from its registered carry-in.
        always_comb begin
            bp_s        = a_in_s[SW-1:0] ^ b_in_s[SW-1:0];
            bg_s        = a_in_s[SW-1:0] & b_in_s[SW-1:0];
            gp_s        = '0;
            gg_s        = '0;
            slice_sum_s = '0;
            for (int j = 0; j < GPS; j++) begin
                {gp_s[j], gg_s[j]} = grp_pg(bp_s[4*j +: 4], bg_s[4*j +: 4]);
            end
            gc_s = grp_carries(gp_s, gg_s, c_in_s);
            for (int j = 0; j < GPS; j++) begin
                slice_sum_s[4*j +: 4] = sum4(bp_s[4*j +: 4], bg_s[4*j +: 4], gc_s[j]);
            end
            slice_p_s = &gp_s;
            slice_g_s = 1'b0;
            for (int j = 0; j < GPS; j++) begin
                slice_g_s = gg_s[j] | (gp_s[j] & slice_g_s);
            end
        end

        // Stage valid, carry, accumulated word P/G and completed sum bits.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                p_q <= 1'b0;
                g_q <= 1'b0;
                s_q <= '0;
            end else if (adv_s) begin
                v_q <= v_in_s;
                c_q <= gc_s[GPS];
                p_q <= slice_p_s & p_in_s;
                g_q <= slice_g_s | (slice_p_s & g_in_s);
                s_q <= s_d;
            end
        end

        if (REM_OUT > 0) begin : g_fwd
            logic [REM_OUT-1:0] a_q;
            logic [REM_OUT-1:0] b_q;

            assign s_d = s_raw_s;

            // Skew registers: operand bits still to be added by later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv_s) begin
                    a_q <= a_in_s[REM_IN-1:SW];
                    b_q <= b_in_s[REM_IN-1:SW];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Signed overflow uses the unsaturated MSB of the sum.
            assign ovf_d = (a_in_s[SW-1] == b_in_s[SW-1]) && (slice_sum_s[SW-1] != a_in_s[SW-1]);

`ifdef CLA_SAT_EN
            // Clamp to the most positive or most negative value on overflow.
            always_comb begin
                if (ovf_d) begin
                    s_d = a_in_s[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end else begin
                    s_d = s_raw_s;
                end
            end
`else
            assign s_d = s_raw_s;
`endif

            // Registered overflow flag, aligned with the output sum.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv_s) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign P         = g_stage[STAGES-1].p_q;
    assign G         = g_stage[STAGES-1].g_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, GROUPS_PER_STAGE=2).
// Results are compared as {cout, ovf, P, G, sum} against an in-order queue.
module tb_pipelined_cla_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        P;
    logic        G;

    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    int          stall_cnt = 0;
    logic [19:0] exp_q[$];
    logic [19:0] cur_exp;
    logic        stall_prev = 1'b0;
    logic [19:0] snap;

    // Directed vectors: a, b, cin, sub and hand-computed {cout,ovf,P,G,sum}.
    logic [15:0] va   [8] = '{16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h00FF, 16'h0007, 16'h1234};
    logic [15:0] vb   [8] = '{16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'hFFFF, 16'hFF00, 16'h0005, 16'h1111};
    logic        vcin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vsub [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef CLA_SAT_EN
    logic [19:0] vexp [8] = '{20'h90000, 20'h0FFFE, 20'h90002, 20'h47FFF, 20'hD8000, 20'hA0000, 20'h90002, 20'h02346};
`else
    logic [19:0] vexp [8] = '{20'h90000, 20'h0FFFE, 20'h90002, 20'h48000, 20'hD7FFF, 20'hA0000, 20'h90002, 20'h02346};
`endif

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .P(P), .G(G)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on 17-bit sums.
    function automatic logic [19:0] model(input logic [15:0] a_v, input logic [15:0] b_v,
                                          input logic cin_v, input logic sub_v);
        logic [15:0] bb;
        logic [16:0] full;
        logic [16:0] nc;
        logic [15:0] s;
        logic        o;
        bb   = sub_v ? ~b_v : b_v;
        full = {1'b0, a_v} + {1'b0, bb} + (sub_v ? 17'd1 : {16'd0, cin_v});
        nc   = {1'b0, a_v} + {1'b0, bb};
        s    = full[15:0];
        o    = (a_v[15] == bb[15]) && (s[15] != a_v[15]);
`ifdef CLA_SAT_EN
        if (o) s = a_v[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {full[16], o, &(a_v ^ bb), nc[16], s};
    endfunction

    // One clock: sample at negedge, score handshakes, then advance past posedge.
    task automatic tick(output logic acc);
        logic [19:0] o;
        logic        deliver;
        @(negedge clk);
        o       = {cout, ovf, P, G, sum};
        deliver = out_valid && out_ready;
        acc     = in_valid && in_ready && !rst;
        if (out_valid && !out_ready) begin
            stall_cnt++;
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            if (stall_prev) check_eq("stall_hold", 32'({out_valid, o}), 32'({1'b1, snap}));
            snap       = o;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
        if (exp_q.size() == 0) begin
            if (!rst) check_eq("no_extra_beat", 32'(out_valid), 32'd0);
        end else if (deliver) begin
            check_eq("result", 32'(o), 32'(exp_q.pop_front()));
            delivered++;
        end
        if (acc) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input int i);
        a       = va[i];
        b       = vb[i];
        cin     = vcin[i];
        sub     = vsub[i];
        cur_exp = vexp[i];
    endtask

    task automatic drain();
        logic acc;
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick(acc);
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   n_acc;
        rst = 1'b1; in_valid = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; cur_exp = 20'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'({out_valid, cout, ovf, P, G, sum}), 32'd0);
        rst = 1'b0;
        check_eq("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Latency: result appears exactly two edges after accept.
        drive_vec(0);
        in_valid = 1'b1;
        tick(acc);
        check_eq("accept_first", 32'(acc), 32'd1);
        in_valid = 1'b0;
        check_eq("lat_edge1", 32'(out_valid), 32'd0);
        tick(acc);
        check_eq("lat_edge2", 32'(out_valid), 32'd1);
        drain();

        // Remaining directed vectors back to back.
        for (int i = 1; i < 8; i++) begin
            drive_vec(i);
            in_valid = 1'b1;
            tick(acc);
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: 4 beats, out_ready low for 5 cycles mid-stream.
        delivered = 0;
        stall_cnt = 0;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            if (idx < 4) begin
                drive_vec(idx);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick(acc);
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_delivered", 32'(delivered), 32'd4);
        check_eq("bp_stall_cycles", 32'(stall_cnt), 32'd5);
        check_eq("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight: neither may ever be delivered.
        delivered = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_vec(i + 2);
            in_valid = 1'b1;
            tick(acc);
        end
        in_valid = 1'b0;
        check_eq("inflight_before_rst", 32'(exp_q.size()), 32'd2);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        exp_q.delete();
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (6) tick(acc);
        check_eq("rst_mid_none_delivered", 32'(delivered), 32'd0);

        // Random soak against the reference model.
        n_acc = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            cur_exp   = model(a, b, cin, sub);
            tick(acc);
            if (acc) n_acc++;
            if (n_acc >= 1000 && exp_q.size() == 0) break;
        end
        check_eq("soak_accepted", 32'(n_acc), 32'd1000);
        check_eq("soak_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
